// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the instruction/data memory arbiter.
package mem_arb_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM signals of the arbiter; master = arbiter, slave = environment.
interface mem_arbiter_if;
  import mem_arb_pkg::*;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts data grants taken while an instruction fetch waits; saturates at LIMIT.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_dserv_entry,
  input  logic i_iserv_entry,
  input  logic i_iren,
  output logic o_at_limit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  assign o_at_limit = (r_cnt == W'(LIMIT));
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_cnt <= '0;
    else if (i_iserv_entry) r_cnt <= '0;
    else if (i_dserv_entry && i_iren && !o_at_limit) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data over instruction; define MEM_ARB_STARVE_GUARD_EN
// to force an instruction grant after STARVE_LIMIT data grants taken while iREN waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);
  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_ram_err;
  logic       w_dreq, w_acc, w_ds, w_is, w_pick_i;
  assign w_dreq = bus.dREN | bus.dWEN;
  assign w_acc  = (bus.ramstate == ACCESS);
  assign w_ds   = (r_state == DSERV);
  assign w_is   = (r_state == ISERV);
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic w_at_limit;
  mem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .CLK           (CLK),
    .nRST          (nRST),
    .i_dserv_entry (r_state == IDLE && w_next == DSERV),
    .i_iserv_entry (r_state == IDLE && w_next == ISERV),
    .i_iren        (bus.iREN),
    .o_at_limit    (w_at_limit)
  );
  assign w_pick_i = w_at_limit & bus.iREN;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^STARVE_LIMIT;
  assign w_pick_i = 1'b0;
`endif
  // A dropped request ends service just like ACCESS does.
  assign w_next = (r_state == IDLE)  ? (w_pick_i ? ISERV : w_dreq ? DSERV : bus.iREN ? ISERV : IDLE) :
                  (r_state == DSERV) ? ((w_dreq & ~w_acc) ? DSERV : IDLE) :
                                       ((bus.iREN & ~w_acc) ? ISERV : IDLE);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state   <= IDLE;
      r_ram_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.ramstate == ERROR) r_ram_err <= 1'b1;
    end
  assign bus.ramaddr  = w_ds ? bus.daddr : w_is ? bus.iaddr : '0;
  assign bus.ramstore = w_ds ? bus.dstore : '0;
  assign bus.ramWEN   = w_ds & bus.dWEN;
  assign bus.ramREN   = w_ds ? (bus.dREN & ~bus.dWEN) : (w_is & bus.iREN);
  assign bus.dwait    = w_ds ? ~w_acc : w_dreq;
  assign bus.iwait    = w_is ? ~w_acc : bus.iREN;
  assign bus.dload    = w_ds ? bus.ramload : '0;
  assign bus.iload    = w_is ? bus.ramload : '0;
  assign bus.ram_err  = r_ram_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus; expected completions queued, matched by a negedge monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] load;
    bit          wen;
  } exp_t;
  logic CLK, nRST;
  exp_t q[$];
  int tests = 0, fails = 0;
  mem_arbiter_if bus ();
  mem_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic take(input bit is_d, input logic [31:0] addr, input logic [31:0] load, input logic wen);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_grant: got side=%0d addr=%h expected no grant", is_d, addr);
    end else begin
      e = q.pop_front();
      chk("grant_side", 32'(is_d), 32'(e.is_d));
      chk("grant_addr", addr, e.addr);
      chk("grant_load", load, e.load);
      chk("grant_wen", 32'(wen), 32'(e.wen));
    end
  endtask
  always @(negedge CLK)
    if (nRST) begin
      if ((bus.dREN | bus.dWEN) && !bus.dwait) take(1'b1, bus.ramaddr, bus.dload, bus.ramWEN);
      else if (bus.iREN && !bus.iwait) take(1'b0, bus.ramaddr, bus.iload, bus.ramWEN);
    end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input bit is_d, input logic [31:0] addr, input logic [31:0] load, input bit wen);
    exp_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.load = load;
    e.wen = wen;
    q.push_back(e);
  endtask
  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h0000_0999; bus.dstore = 32'h1234_5678;
    bus.ramload = 32'hFFFF_FFFF; bus.ramstate = FREE;
    step(); step();
    @(negedge CLK);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload, 0);
    chk("rst_ram_err", 32'(bus.ram_err), 0);
    // Instruction fetch, ACCESS on the second cycle
    step();
    nRST = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    @(negedge CLK);
    chk("i_idle_iwait", 32'(bus.iwait), 1);
    chk("i_idle_ramREN", 32'(bus.ramREN), 0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h8C01_0004;
    push(1'b0, 32'h40, 32'h8C01_0004, 1'b0);
    @(negedge CLK);
    chk("i_serv_ramREN", 32'(bus.ramREN), 1);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk("i_back_idle_addr", bus.ramaddr, 0);
    // Simultaneous iREN and dWEN: data wins
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.dWEN = 1'b1; bus.daddr = 32'h100;
    bus.dstore = 32'hDEAD_BEEF; bus.ramstate = BUSY;
    @(negedge CLK);
    chk("both_idle_dwait", 32'(bus.dwait), 1);
    chk("both_idle_ramWEN", 32'(bus.ramWEN), 0);
    step();
    @(negedge CLK);
    chk("both_ramWEN", 32'(bus.ramWEN), 1);
    chk("both_ramREN", 32'(bus.ramREN), 0);
    chk("both_ramaddr", bus.ramaddr, 32'h100);
    chk("both_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    chk("both_iwait", 32'(bus.iwait), 1);
    chk("both_dwait_busy", 32'(bus.dwait), 1);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h1111_1111;
    push(1'b1, 32'h100, 32'h1111_1111, 1'b1);
    step();
    bus.dWEN = 1'b0; bus.ramstate = BUSY;
    @(negedge CLK);
    chk("gap_ramaddr", bus.ramaddr, 0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h2222_2222;
    push(1'b0, 32'h200, 32'h2222_2222, 1'b0);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    // dREN and dWEN together: write wins
    step();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h5A5A_5A5A; bus.ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("rw_ramWEN", 32'(bus.ramWEN), 1);
    chk("rw_ramREN", 32'(bus.ramREN), 0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h3333_3333;
    push(1'b1, 32'h300, 32'h3333_3333, 1'b1);
    step();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    // ERROR holds the state and latches ram_err
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
    step();
    bus.ramstate = ERROR;
    @(negedge CLK);
    chk("err_before_edge", 32'(bus.ram_err), 0);
    chk("err_ramREN", 32'(bus.ramREN), 1);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h4444_4444;
    push(1'b1, 32'h400, 32'h4444_4444, 1'b0);
    @(negedge CLK);
    chk("err_set", 32'(bus.ram_err), 1);
    step();
    bus.dREN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk("err_sticky", 32'(bus.ram_err), 1);
    // Requester drops mid-service
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("drop_ramREN_on", 32'(bus.ramREN), 1);
    step();
    bus.iREN = 1'b0;
    @(negedge CLK);
    chk("drop_ramREN_off", 32'(bus.ramREN), 0);
    chk("drop_still_iserv", bus.ramaddr, 32'h500);
    step();
    @(negedge CLK);
    chk("drop_idle_addr", bus.ramaddr, 0);
    // Async reset mid-DSERV
    step();
    bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h6060_6060;
    step();
    @(negedge CLK);
    chk("rst_mid_ramWEN_on", 32'(bus.ramWEN), 1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_ramWEN", 32'(bus.ramWEN), 0);
    chk("rst_mid_ramaddr", bus.ramaddr, 0);
    chk("rst_mid_ram_err", 32'(bus.ram_err), 0);
    step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rel_no_grant", 32'(bus.ramWEN), 0);
    step();
    @(negedge CLK);
    chk("rel_grant", 32'(bus.ramWEN), 1);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h6666_6666;
    push(1'b1, 32'h600, 32'h6666_6666, 1'b1);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    // Continuous data plus instruction traffic
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h700; bus.iREN = 1'b1; bus.iaddr = 32'h800;
    bus.ramstate = ACCESS; bus.ramload = 32'h7777_7777;
    for (int i = 0; i < 5; i++)
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (i == 4) push(1'b0, 32'h800, 32'h7777_7777, 1'b0);
      else push(1'b1, 32'h700, 32'h7777_7777, 1'b0);
`else
      push(1'b1, 32'h700, 32'h7777_7777, 1'b0);
`endif
    for (int i = 0; i < 10; i++) step();
    bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;
    step(); step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
